// File: rtl/ti_packet_framer_if.sv
// Byte handshake bundle for the TI link packet framer.
// master = framer side, slave = upstream/downstream environment side.
interface ti_packet_framer_if;
  logic [7:0] i_data;
  logic       i_avail;
  logic       o_read;
  logic [7:0] o_data;
  logic       o_avail;
  logic       i_read;
  logic       o_sop;
  logic       o_eop;
  logic       o_cksumerr;
  logic       o_lenerr;

  modport master (
    input  i_data, i_avail, i_read,
    output o_read, o_data, o_avail,
    output o_sop, o_eop, o_cksumerr, o_lenerr
  );

  modport slave (
    output i_data, i_avail, i_read,
    input  o_read, o_data, o_avail,
    input  o_sop, o_eop, o_cksumerr, o_lenerr
  );
endinterface

// File: rtl/ti_packet_framer.sv
// TI link packet framer: forwards bytes with sop/eop marks,
// checksum/length verdicts and an inter-byte timeout abort.
module ti_packet_framer #(
  parameter int c_TIMEOUT = 400000,
  parameter int c_MAXLEN  = 65535
) (
  input  logic               i_clock,
  input  logic               i_reset,
  ti_packet_framer_if.master bus,
  output logic               o_abort,
  output logic               o_inpacket,
  output logic [15:0]        o_pktcount,
  output logic [15:0]        o_errcount
);

  localparam int TW = $clog2(c_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(c_TIMEOUT - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CMD  = 3'd1;
  localparam logic [2:0] LENL = 3'd2;
  localparam logic [2:0] LENH = 3'd3;
  localparam logic [2:0] DATA = 3'd4;
  localparam logic [2:0] CKL  = 3'd5;
  localparam logic [2:0] CKH  = 3'd6;

  function automatic logic is_data_cmd(input logic [7:0] c);
    case (c)
      8'h06, 8'h15, 8'h36,
      8'h88, 8'hA2, 8'hC9: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    lenl_q, lenl_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   rem_q, rem_d;
  logic [15:0]   sum_q, sum_d;
  logic [7:0]    ckl_q, ckl_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          read_q, read_d;
  logic          full_q, full_d;
  logic          pend_q, pend_d;
  logic          avail_q, avail_d;
  logic [7:0]    data_q, data_d;
  logic          sop_q, sop_d;
  logic          eop_q, eop_d;
  logic          ckerr_q, ckerr_d;
  logic          lenerr_q, lenerr_d;
  logic          abort_q, abort_d;
  logic [15:0]   pkt_q, pkt_d;
  logic [15:0]   err_q, err_d;
  logic          capture;

  assign capture = !read_q && bus.i_avail && !full_q;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    lenl_d   = lenl_q;
    len_d    = len_q;
    rem_d    = rem_q;
    sum_d    = sum_q;
    ckl_d    = ckl_q;
    tmo_d    = tmo_q;
    read_d   = read_q;
    full_d   = full_q;
    pend_d   = pend_q;
    avail_d  = avail_q;
    data_d   = data_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    ckerr_d  = ckerr_q;
    lenerr_d = lenerr_q;
    abort_d  = 1'b0;
    pkt_d    = pkt_q;
    err_d    = err_q;

    if (capture)
      read_d = 1'b1;
    else if (read_q && !bus.i_avail)
      read_d = 1'b0;

    // Register is held until the downstream four-phase cycle completes
    if (pend_q) begin
      pend_d  = 1'b0;
      avail_d = 1'b1;
    end else if (avail_q && bus.i_read) begin
      avail_d = 1'b0;
    end else if (full_q && !avail_q && !bus.i_read) begin
      full_d = 1'b0;
    end

    if (capture) begin
      data_d   = bus.i_data;
      full_d   = 1'b1;
      pend_d   = 1'b1;
      sop_d    = 1'b0;
      eop_d    = 1'b0;
      ckerr_d  = 1'b0;
      lenerr_d = 1'b0;
      tmo_d    = '0;
      case (state_q)
        IDLE: begin
          sop_d   = 1'b1;
          sum_d   = '0;
          rem_d   = '0;
          state_d = CMD;
        end
        CMD: begin
          cmd_d   = bus.i_data;
          state_d = LENL;
        end
        LENL: begin
          lenl_d  = bus.i_data;
          state_d = LENH;
        end
        LENH: begin
          len_d = {bus.i_data, lenl_q};
          rem_d = {bus.i_data, lenl_q};
          if (!is_data_cmd(cmd_q)) begin
            eop_d   = 1'b1;
            pkt_d   = pkt_q + 16'd1;
            state_d = IDLE;
          end else if ({bus.i_data, lenl_q} == 16'd0) begin
            state_d = CKL;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          sum_d = sum_q + {8'd0, bus.i_data};
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1)
            state_d = CKL;
        end
        CKL: begin
          ckl_d   = bus.i_data;
          state_d = CKH;
        end
        CKH: begin
          eop_d    = 1'b1;
          ckerr_d  = {bus.i_data, ckl_q} != sum_q;
          lenerr_d = {16'd0, len_q} > c_MAXLEN;
          pkt_d    = pkt_q + 16'd1;
          if ({bus.i_data, ckl_q} != sum_q)
            err_d = err_q + 16'd1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      tmo_d = '0;
    end else if (!bus.i_avail) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        state_d = IDLE;
        abort_d = 1'b1;
        err_d   = err_q + 16'd1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      lenl_q   <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      sum_q    <= '0;
      ckl_q    <= '0;
      tmo_q    <= '0;
      read_q   <= 1'b0;
      full_q   <= 1'b0;
      pend_q   <= 1'b0;
      avail_q  <= 1'b0;
      data_q   <= '0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      ckerr_q  <= 1'b0;
      lenerr_q <= 1'b0;
      abort_q  <= 1'b0;
      pkt_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      lenl_q   <= lenl_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      sum_q    <= sum_d;
      ckl_q    <= ckl_d;
      tmo_q    <= tmo_d;
      read_q   <= read_d;
      full_q   <= full_d;
      pend_q   <= pend_d;
      avail_q  <= avail_d;
      data_q   <= data_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      ckerr_q  <= ckerr_d;
      lenerr_q <= lenerr_d;
      abort_q  <= abort_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_read     = read_q;
  assign bus.o_data     = data_q;
  assign bus.o_avail    = avail_q;
  assign bus.o_sop      = sop_q;
  assign bus.o_eop      = eop_q;
  assign bus.o_cksumerr = ckerr_q;
  assign bus.o_lenerr   = lenerr_q;
  assign o_abort        = abort_q;
  assign o_inpacket     = state_q != IDLE;
  assign o_pktcount     = pkt_q;
  assign o_errcount     = err_q;

endmodule

// File: tb/tb_ti_packet_framer.sv
// Testbench for ti_packet_framer: randomized handshakes checked
// against a packet-level model of the expected byte stream.
module tb_ti_packet_framer;
  localparam int TMO  = 16;
  localparam int MAXL = 300;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ti_packet_framer_if bus ();
  logic        o_abort, o_inpacket;
  logic [15:0] pktc, errc;

  ti_packet_framer #(.c_TIMEOUT(TMO), .c_MAXLEN(MAXL)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .bus        (bus),
    .o_abort    (o_abort),
    .o_inpacket (o_inpacket),
    .o_pktcount (pktc),
    .o_errcount (errc)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       ck;
    logic       le;
  } rec_t;

  logic [7:0]  up_q[$];
  logic [7:0]  pay_q[$];
  rec_t        exp_q[$];
  rec_t        obs_q[$];
  bit          drv_en, rd_en;
  logic [15:0] exp_pkt, exp_err;
  int          n_cmp, n_fail;
  int          cyc, drop_cyc, abort_cyc, abort_cnt, read_rises;
  logic        rd_prev;

  always @(posedge clk) cyc <= cyc + 1;

  // upstream four-phase producer with random gaps
  initial forever begin
    @(posedge clk); #1;
    if (drv_en) begin
      if (bus.i_avail) begin
        if (bus.o_read) begin
          bus.i_avail = 1'b0;
          drop_cyc = cyc;
        end
      end else if (!bus.o_read && up_q.size() > 0
                   && $urandom_range(0, 3) != 0) begin
        bus.i_data  = up_q.pop_front();
        bus.i_avail = 1'b1;
      end
    end
  end

  // downstream four-phase consumer with random acceptance
  initial forever begin
    @(posedge clk); #1;
    if (bus.i_read && !bus.o_avail) begin
      bus.i_read = 1'b0;
    end else if (rd_en && bus.o_avail && !bus.i_read
                 && $urandom_range(0, 1) == 1) begin
      obs_q.push_back({bus.o_data, bus.o_sop, bus.o_eop,
                       bus.o_eop & bus.o_cksumerr,
                       bus.o_eop & bus.o_lenerr});
      bus.i_read = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (o_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    if (bus.o_read && !rd_prev) read_rises++;
    rd_prev = bus.o_read;
  end

  function automatic bit is_dcmd(input logic [7:0] c);
    return c inside {8'h06, 8'h15, 8'h36, 8'h88, 8'hA2, 8'hC9};
  endfunction

  // Reference model: build bytes and expected records from packet fields
  task automatic add_pkt(input logic [7:0] mid, input logic [7:0] cmd,
                         input logic [15:0] len, input bit bad);
    logic [7:0]  b[$];
    logic [15:0] sum, ck;
    bit          dc;
    rec_t        r;
    dc  = is_dcmd(cmd);
    sum = 16'd0;
    b   = {mid, cmd, len[7:0], len[15:8]};
    if (dc) begin
      for (int i = 0; i < int'(len); i++) begin
        b.push_back(pay_q[i]);
        sum = sum + 16'(pay_q[i]);
      end
      ck = sum + (bad ? 16'd1 : 16'd0);
      b.push_back(ck[7:0]);
      b.push_back(ck[15:8]);
    end
    foreach (b[i]) begin
      r.d   = b[i];
      r.sop = (i == 0);
      r.eop = (i == b.size() - 1);
      r.ck  = r.eop && dc && bad;
      r.le  = r.eop && dc && (int'(len) > MAXL);
      up_q.push_back(b[i]);
      exp_q.push_back(r);
    end
    exp_pkt = exp_pkt + 16'd1;
    if (dc && bad) exp_err = exp_err + 16'd1;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    ok = (obs_q.size() >= n);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
    pay_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.o_read, bus.o_avail, bus.o_data, bus.o_sop, bus.o_eop,
         bus.o_cksumerr, bus.o_lenerr, o_abort, o_inpacket,
         pktc, errc} !== 47'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd=%b av=%b d=%h ip=%b pkt=%h err=%h want all 0",
               bus.o_read, bus.o_avail, bus.o_data, o_inpacket, pktc, errc);
    end
    rst = 1'b0;
    drv_en = 1'b1;
    rd_en  = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.o_avail, o_inpacket, pktc} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_release: got av=%b ip=%b pkt=%h want 0",
               bus.o_avail, o_inpacket, pktc);
    end
  endtask

  task automatic test_header_only();
    bit ok;
    clear_q();
    add_pkt(8'h08, 8'h56, 16'h0000, 1'b0);
    wait_obs(exp_q.size(), 500, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL hdr_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL hdr_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (pktc !== 16'd1 || errc !== 16'd0) begin
      n_fail++;
      $display("FAIL hdr_counters: got pkt=%0d err=%0d want 1/0", pktc, errc);
    end
  endtask

  task automatic test_data_packet();
    bit ok;
    for (int bad = 0; bad < 2; bad++) begin
      clear_q();
      pay_q = {8'h01, 8'h02, 8'h03};
      add_pkt(8'h08, 8'h15, 16'd3, bad[0]);
      wait_obs(exp_q.size(), 800, ok);
      n_cmp++;
      if (!ok || obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL data%0d_count: got %0d bytes want %0d",
                 bad, obs_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL data%0d_byte[%0d]: got %h want %h",
                   bad, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++;
      if (pktc !== exp_pkt || errc !== exp_err) begin
        n_fail++;
        $display("FAIL data%0d_counters: got pkt=%0d err=%0d want %0d/%0d",
                 bad, pktc, errc, exp_pkt, exp_err);
      end
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_q();
    add_pkt(8'h08, 8'h15, 16'd0, 1'b0);
    wait_obs(exp_q.size(), 500, ok);
    n_cmp++;
    if (!ok || obs_q.size() != 6) begin
      n_fail++;
      $display("FAIL zlen_count: got %0d bytes want 6", obs_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL zlen_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    bit          ok;
    int          ab0, k;
    logic [7:0]  b[$];
    rec_t        r;
    clear_q();
    b = {8'h08, 8'h15, 8'h05, 8'h00, 8'hAA, 8'hBB};
    foreach (b[i]) begin
      r = {b[i], i == 0, 1'b0, 1'b0, 1'b0};
      up_q.push_back(b[i]);
      exp_q.push_back(r);
    end
    ab0 = abort_cnt;
    wait_obs(6, 500, ok);
    k = 0;
    while (abort_cnt == ab0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_cmp++;
    if (abort_cnt != ab0 + 1) begin
      n_fail++;
      $display("FAIL tmo_abort: got %0d pulses want 1", abort_cnt - ab0);
    end
    n_cmp++;
    if (abort_cyc - drop_cyc != TMO) begin
      n_fail++;
      $display("FAIL tmo_latency: got %0d cycles want %0d",
               abort_cyc - drop_cyc, TMO);
    end
    exp_err = exp_err + 16'd1;
    n_cmp++;
    if (o_inpacket !== 1'b0 || errc !== exp_err || pktc !== exp_pkt) begin
      n_fail++;
      $display("FAIL tmo_state: got ip=%b err=%0d pkt=%0d want 0/%0d/%0d",
               o_inpacket, errc, pktc, exp_err, exp_pkt);
    end
    n_cmp++;
    if (!ok || obs_q.size() != 6) begin
      n_fail++;
      $display("FAIL tmo_count: got %0d bytes want 6", obs_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL tmo_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear_q();
    add_pkt(8'h08, 8'h56, 16'h0000, 1'b0);
    wait_obs(4, 500, ok);
    n_cmp++;
    if (!ok || obs_q.size() != 4 || obs_q[0] !== exp_q[0] || obs_q[3] !== exp_q[3]) begin
      n_fail++;
      $display("FAIL tmo_recover: got %0d bytes first=%h want first=%h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : rec_t'(0), exp_q[0]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int r0, ab0;
    clear_q();
    rd_en = 1'b0;
    repeat (4) pay_q.push_back(8'($urandom));
    add_pkt(8'h08, 8'hA2, 16'd4, 1'b0);
    r0  = read_rises;
    ab0 = abort_cnt;
    repeat (100) @(posedge clk);
    #1;
    n_cmp++;
    if (read_rises - r0 != 1 || bus.o_avail !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got reads=%0d avail=%b want 1/1",
               read_rises - r0, bus.o_avail);
    end
    n_cmp++;
    if (abort_cnt != ab0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_abort: got aborts=%0d bytes=%0d want 0/0",
               abort_cnt - ab0, obs_q.size());
    end
    rd_en = 1'b1;
    wait_obs(exp_q.size(), 800, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL bp_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit          ok;
    logic [7:0]  cmd;
    logic [15:0] len;
    clear_q();
    for (int p = 0; p < 30; p++) begin
      pay_q.delete();
      if ($urandom_range(0, 1) == 1) begin
        cmd = 8'h06;
        case ($urandom_range(0, 5))
          0: cmd = 8'h06;
          1: cmd = 8'h15;
          2: cmd = 8'h36;
          3: cmd = 8'h88;
          4: cmd = 8'hA2;
          default: cmd = 8'hC9;
        endcase
        len = (p == 5 || p == 17) ? 16'(MAXL + $urandom_range(1, 3))
                                  : 16'($urandom_range(0, 12));
        for (int i = 0; i < int'(len); i++) pay_q.push_back(8'($urandom));
      end else begin
        do cmd = 8'($urandom); while (is_dcmd(cmd));
        len = 16'($urandom);
      end
      add_pkt(8'($urandom), cmd, len, $urandom_range(0, 2) == 0);
    end
    wait_obs(exp_q.size(), 40000, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rnd_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (pktc !== exp_pkt || errc !== exp_err) begin
      n_fail++;
      $display("FAIL rnd_counters: got pkt=%0d err=%0d want %0d/%0d",
               pktc, errc, exp_pkt, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    bit         ok;
    int         k;
    logic [7:0] b[$];
    clear_q();
    b = {8'h08, 8'h88, 8'h0A, 8'h00, 8'h11, 8'h22, 8'h33};
    foreach (b[i]) up_q.push_back(b[i]);
    wait_obs(7, 800, ok);
    rd_en = 1'b0;
    up_q.push_back(8'h44);
    k = 0;
    while (!bus.o_avail && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    n_cmp++;
    if (!ok || bus.o_avail !== 1'b1 || o_inpacket !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup: got ok=%b avail=%b ip=%b want 1/1/1",
               ok, bus.o_avail, o_inpacket);
    end
    drv_en = 1'b0;
    up_q.delete();
    bus.i_avail = 1'b0;
    bus.i_read  = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.o_read, bus.o_avail, bus.o_data, bus.o_sop, bus.o_eop,
         bus.o_cksumerr, bus.o_lenerr, o_abort, o_inpacket,
         pktc, errc} !== 47'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got rd=%b av=%b d=%h ip=%b pkt=%h err=%h want all 0",
               bus.o_read, bus.o_avail, bus.o_data, o_inpacket, pktc, errc);
    end
    rst = 1'b0;
    exp_pkt = 16'd0;
    exp_err = 16'd0;
    clear_q();
    drv_en = 1'b1;
    rd_en  = 1'b1;
    pay_q = {8'hF0, 8'h0F};
    add_pkt(8'h08, 8'hC9, 16'd2, 1'b0);
    wait_obs(exp_q.size(), 800, ok);
    n_cmp++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d bytes want %0d", obs_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_byte[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (pktc !== 16'd1 || errc !== 16'd0) begin
      n_fail++;
      $display("FAIL rstmid_counters: got pkt=%0d err=%0d want 1/0", pktc, errc);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    drop_cyc = 0;
    abort_cyc = 0;
    abort_cnt = 0;
    read_rises = 0;
    rd_prev = 1'b0;
    exp_pkt = 16'd0;
    exp_err = 16'd0;
    drv_en = 1'b0;
    rd_en = 1'b0;
    bus.i_data = 8'h00;
    bus.i_avail = 1'b0;
    bus.i_read = 1'b0;
    rst = 1'b1;
    test_reset();
    test_header_only();
    test_data_packet();
    test_zero_len();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ti_packet_framer.md
Name: ti_packet_framer

Overview:
- Byte-stream stage directly downstream of the dbus receiver and upstream of the UART TX FIFO in the bridge.
- Consumes raw received link bytes and parses TI link packet framing: header of machine ID, command, length low, length high; optional payload; 16-bit checksum.
- Forwards every byte unchanged, with start/end-of-packet marks and a per-packet checksum verdict.
- Applies an inter-byte timeout so a stalled or truncated packet cannot wedge the framer.

Parameters:
- c_TIMEOUT, 400000: idle cycles mid-packet before abort (100 ms at 4 MHz).
- c_MAXLEN, 65535: largest accepted payload length; larger lengths flag o_lenerr.

Ports:
- i_clock  in  1  single clock, all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_data  in  8  upstream byte, valid while i_avail is high.
- i_avail  in  1  upstream byte available (level).
- o_read  out  1  upstream accept, four-phase.
- o_data  out  8  forwarded byte.
- o_avail  out  1  output byte valid (level).
- i_read  in  1  downstream accept, four-phase.
- o_sop  out  1  o_data is the first header byte (machine ID); qualified by o_avail.
- o_eop  out  1  o_data is the last byte of the packet; qualified by o_avail.
- o_cksumerr  out  1  checksum mismatch; meaningful when o_eop=1.
- o_lenerr  out  1  length > c_MAXLEN; meaningful when o_eop=1.
- o_abort  out  1  one-cycle pulse on timeout abort.
- o_inpacket  out  1  parser state is not IDLE.
- o_pktcount  out  16  packets completed, wraps at 0xFFFF->0.
- o_errcount  out  16  checksum errors plus aborts, wraps.

Behaviour:
- Reset values, all outputs: o_read=0, o_avail=0, o_data=0, o_sop=0, o_eop=0, o_cksumerr=0, o_lenerr=0, o_abort=0, o_inpacket=0, counters=0, state=IDLE.
- Reset mid-packet or mid-handshake: pending output byte is dropped and the handshake is abandoned.
- Upstream handshake:
  - o_read rises when i_avail=1, o_read=0 and the output register is empty; i_data is captured on that edge.
  - o_read falls on the first cycle i_avail is seen low.
  - Exactly one byte per o_read high period.
- Downstream handshake:
  - Output register is filled on the capture edge, so o_avail goes high 1 cycle after o_read rises.
  - o_avail falls on the first cycle i_read is seen high.
  - The register frees only after i_read returns low. No new capture while the register is occupied.
- FSM (advances one state per captured byte):
  - IDLE: byte is the machine ID, mark sop -> CMD.
  - CMD: latch command -> LENL.
  - LENL: latch length low byte -> LENH.
  - LENH: latch length high byte. Data command: len=0 -> CKL, else -> DATA. Non-data command: mark eop -> IDLE.
  - DATA: add byte to 16-bit running sum, mod 2^16. Decrement the remaining count; on the last byte -> CKL.
  - CKL: latch checksum low byte -> CKH.
  - CKH: mark eop; o_cksumerr = ({byte,CKL} != sum); o_lenerr from the latched length -> IDLE.
- Data-carrying commands: 0x06, 0x15, 0x36, 0x88, 0xA2, 0xC9. All other commands are header-only, and their length field is forwarded but ignored.
- Oversized length is still framed using the full 16-bit length. o_lenerr is reported at eop.
- Sum and remaining count clear on entry to CMD.
- Counters, updated when the eop byte is captured:
  - o_pktcount increments on every eop.
  - o_errcount increments on eop with o_cksumerr=1, and on every abort.
- Timeout:
  - Counter runs while state != IDLE and i_avail=0; it clears on every capture and while in IDLE.
  - The counter does not run during downstream backpressure while i_avail=1.
  - Reaching c_TIMEOUT: state -> IDLE, o_abort pulses 1 cycle, o_errcount increments. The output register is unaffected; no eop is generated for the truncated packet.
  - If timeout expiry and a capture occur in the same cycle, the capture wins and the timer clears.

Test Plan:
- Header-only packet 0x08,0x56,0x00,0x00 (ACK) -> 4 bytes out in order; sop on byte 0, eop on byte 3; o_pktcount=1; o_cksumerr=0.
- Data packet 0x08,0x15,0x03,0x00,0x01,0x02,0x03,0x06,0x00 -> eop on the 9th byte, o_cksumerr=0. Same packet with final checksum byte 0x07,0x00 -> o_cksumerr=1, o_errcount=1.
- Data command with len=0: 0x08,0x15,0x00,0x00,0x00,0x00 -> goes directly to checksum bytes; eop on byte 6, o_cksumerr=0.
- Stop after 2 payload bytes of a len=5 packet with c_TIMEOUT=16 -> o_abort pulses 16 cycles after the last i_avail low; o_inpacket=0; o_errcount=1. The next header frames correctly with sop.
- Hold i_read low for 100 cycles while upstream offers bytes -> o_read stays low, no byte lost or duplicated, no abort. Release -> stream resumes byte-exact.
- Assert i_reset in DATA state with o_avail=1 -> next cycle all outputs at reset values; a following packet parses from IDLE.
